cam_fifo_capture: RTL and testbench

//  Parametrised OV7670 + AL422B FIFO frame grabber. Arms FIFO write for one sensor frame,

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_pix_fmt.sv | 40 ++++
 rtl/cam_fifo_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_cam_fifo_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the OV7670 + AL422B frame grabber: FSM states, pixel modes, RGB565 fields.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WRITE = 3'd2,
    RRST  = 3'd3,
    RD_HI = 3'd4,
    RD_LO = 3'd5,
    DONE  = 3'd6
  } cam_state_t;

  localparam logic [1:0] PIX_RGB333 = 2'd0;
  localparam logic [1:0] PIX_LUMA   = 2'd1;
  localparam logic [1:0] PIX_RAW    = 2'd2;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/cam_pix_fmt.sv
// Combinational RGB565 -> STORE_W pixel converter (RGB333, luma, raw MSBs, reserved = 0).
module cam_pix_fmt
  import cam_pkg::*;
#(
  parameter int unsigned STORE_W = 9
) (
  input  logic [15:0]        pix,
  input  logic [1:0]         mode,
  output logic [STORE_W-1:0] q_c
);

  logic [4:0]  r;
  logic [5:0]  g;
  logic [4:0]  b;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [9:0]  sum;
  logic [15:0] wide;

  // Channels are expanded to 8 bits by replicating MSBs before the Y = (R+2G+B)/4 sum.
  always_comb begin
    r    = pix[R_MSB:R_LSB];
    g    = pix[G_MSB:G_LSB];
    b    = pix[B_MSB:B_LSB];
    r8   = {r, r[4:2]};
    g8   = {g, g[5:4]};
    b8   = {b, b[4:2]};
    sum  = 10'(r8) + 10'({g8, 1'b0}) + 10'(b8);
    wide = '0;
    case (mode)
      PIX_RGB333: wide = 16'({r[4:2], g[5:3], b[4:2]});
      PIX_LUMA:   wide = 16'(sum >> 2);
      PIX_RAW:    wide = pix >> (16 - STORE_W);
      default:    wide = '0;
    endcase
    q_c = STORE_W'(wide);
  end

endmodule

// File: rtl/cam_fifo_capture.sv
// OV7670 + AL422B frame grabber: arms one FIFO frame, reads it back, converts, decimates, stores.
// Optional CAM_DOUBLE_BUF_EN: two banks, readers always see the last completed frame.
module cam_fifo_capture
  import cam_pkg::*;
#(
  parameter int unsigned CAM_W    = 320,
  parameter int unsigned CAM_H    = 240,
  parameter int unsigned DS_SHIFT = 1,
  parameter int unsigned STORE_W  = 9,
  parameter int unsigned RRST_CYC = 54000,
  parameter int unsigned TIMEOUT  = 32'd1 << 24,
  localparam int unsigned BUF_W   = CAM_W >> DS_SHIFT,
  localparam int unsigned BUF_H   = CAM_H >> DS_SHIFT,
  localparam int unsigned DEPTH   = BUF_W * BUF_H,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cam_data,
  input  logic               ov_vsync,
  input  logic               start,
  input  logic               continuous,
  input  logic [1:0]         pix_mode,
  output logic               fifo_rclk,
  output logic               fifo_wen,
  output logic               fifo_wrst,
  output logic               fifo_rrst,
  output logic               fifo_oe,
  input  logic [AW-1:0]      rd_addr,
  output logic [STORE_W-1:0] rd_q,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         frame_cnt,
  output logic               err
);

  localparam int unsigned XW      = $clog2(CAM_W);
  localparam int unsigned YW      = $clog2(CAM_H);
  localparam int unsigned CNT_W   = $clog2((RRST_CYC > TIMEOUT) ? RRST_CYC : TIMEOUT);
  localparam int unsigned DS_MASK = (32'd1 << DS_SHIFT) - 32'd1;
`ifdef CAM_DOUBLE_BUF_EN
  localparam int unsigned NBANK   = 2;
`else
  localparam int unsigned NBANK   = 1;
`endif
  localparam int unsigned MW      = $clog2(NBANK * DEPTH);

  cam_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]      x, x_nxt;
  logic [YW-1:0]      y, y_nxt;
  logic [AW-1:0]      wptr, wptr_nxt;
  logic [7:0]         hi, hi_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [7:0]         frame_cnt_nxt;
  logic               err_nxt, wen_nxt, rrst_nxt, busy_nxt, done_nxt;
  logic               vs_m, vs_s, vs_d, vs_rise_c;
  logic               keep_c, we_c;
  logic [STORE_W-1:0] fmt_q_c;
  logic [MW-1:0]      wr_idx_c, rd_idx_c;
  logic [STORE_W-1:0] mem [NBANK*DEPTH];
`ifdef CAM_DOUBLE_BUF_EN
  logic               bank, bank_nxt;
`endif

  assign fifo_rclk = clk;
  assign fifo_oe   = 1'b0;
  assign vs_rise_c = vs_s & ~vs_d;
  assign keep_c    = ((32'(x) & DS_MASK) == 32'd0) && ((32'(y) & DS_MASK) == 32'd0);
  assign we_c      = (state == RD_LO) && keep_c;

`ifdef CAM_DOUBLE_BUF_EN
  // bank selects the front (readable) bank; capture writes the other one.
  assign wr_idx_c = bank ? MW'(wptr) : MW'(wptr) + MW'(DEPTH);
  assign rd_idx_c = bank ? MW'(rd_addr) + MW'(DEPTH) : MW'(rd_addr);
`else
  assign wr_idx_c = MW'(wptr);
  assign rd_idx_c = MW'(rd_addr);
`endif

  cam_pix_fmt #(.STORE_W(STORE_W)) u_fmt (
    .pix  ({hi, cam_data}),
    .mode (mode_q),
    .q_c  (fmt_q_c)
  );

  // vsync synchroniser and FIFO write-pointer reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_m      <= 1'b0;
      vs_s      <= 1'b0;
      vs_d      <= 1'b0;
      fifo_wrst <= 1'b1;
    end else begin
      vs_m      <= ov_vsync;
      vs_s      <= vs_m;
      vs_d      <= vs_s;
      fifo_wrst <= ~vs_s;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    x_nxt         = x;
    y_nxt         = y;
    wptr_nxt      = wptr;
    hi_nxt        = hi;
    mode_nxt      = mode_q;
    err_nxt       = err;
    frame_cnt_nxt = frame_cnt;
`ifdef CAM_DOUBLE_BUF_EN
    bank_nxt      = bank;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          err_nxt   = 1'b0;
        end
      end
      ARM: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (vs_rise_c) begin
          state_nxt = WRITE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      WRITE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (vs_rise_c) begin
          state_nxt = RRST;
          cnt_nxt   = '0;
          mode_nxt  = pix_mode;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      RRST: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(RRST_CYC - 1)) begin
          state_nxt = RD_HI;
          cnt_nxt   = '0;
          x_nxt     = '0;
          y_nxt     = '0;
          wptr_nxt  = '0;
        end
      end
      RD_HI: begin
        hi_nxt    = cam_data;
        state_nxt = RD_LO;
      end
      RD_LO: begin
        state_nxt = RD_HI;
        if (keep_c && (wptr != AW'(DEPTH - 1))) wptr_nxt = wptr + AW'(1);
        if (x == XW'(CAM_W - 1)) begin
          x_nxt = '0;
          if (y == YW'(CAM_H - 1)) state_nxt = DONE;
          else                     y_nxt     = y + YW'(1);
        end else begin
          x_nxt = x + XW'(1);
        end
      end
      DONE: begin
        state_nxt = continuous ? ARM : IDLE;
`ifdef CAM_DOUBLE_BUF_EN
        bank_nxt  = ~bank;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // Registered outputs follow the state being entered.
    wen_nxt  = (state_nxt == WRITE);
    rrst_nxt = (state_nxt != RRST);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    if (done_nxt && (frame_cnt != 8'hFF)) frame_cnt_nxt = frame_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      wptr       <= '0;
      hi         <= '0;
      mode_q     <= PIX_RGB333;
      err        <= 1'b0;
      frame_cnt  <= '0;
      fifo_wen   <= 1'b0;
      fifo_rrst  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef CAM_DOUBLE_BUF_EN
      bank       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      wptr       <= wptr_nxt;
      hi         <= hi_nxt;
      mode_q     <= mode_nxt;
      err        <= err_nxt;
      frame_cnt  <= frame_cnt_nxt;
      fifo_wen   <= wen_nxt;
      fifo_rrst  <= rrst_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
`ifdef CAM_DOUBLE_BUF_EN
      bank       <= bank_nxt;
`endif
    end
  end

  // Frame buffer: contents are not reset.
  always_ff @(posedge clk) begin
    if (we_c) mem[wr_idx_c] <= fmt_q_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= mem[rd_idx_c];
  end

endmodule

// File: tb/tb_cam_fifo_capture.sv
// Bench for cam_fifo_capture: FIFO byte-stream model, scoreboard of expected buffer contents.
module tb_cam_fifo_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cam_data;
  logic        ov_vsync;
  logic        start;
  logic        continuous;
  logic [1:0]  pix_mode;
  logic [2:0]  rd_addr;

  logic        fifo_rclk_a, fifo_wen_a, fifo_wrst_a, fifo_rrst_a, fifo_oe_a;
  logic        busy_a, frame_done_a, err_a;
  logic [7:0]  frame_cnt_a;
  logic [8:0]  rd_q_a;
  logic        fifo_rclk_b, fifo_wen_b, fifo_wrst_b, fifo_rrst_b, fifo_oe_b;
  logic        busy_b, frame_done_b, err_b;
  logic [7:0]  frame_cnt_b;
  logic [15:0] rd_q_b;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last0;
  bit          have_prev;
  logic [15:0] src [32];
  logic [7:0]  fifo_mem [64];
  logic [6:0]  rptr;
  int          total = 0;
  int          bad   = 0;
  int          fcnt  = 0;
  int          n;

  always #5 clk = ~clk;

  cam_fifo_capture #(.CAM_W(8), .CAM_H(4), .DS_SHIFT(1), .STORE_W(9), .RRST_CYC(4), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst), .cam_data(cam_data), .ov_vsync(ov_vsync), .start(start),
    .continuous(continuous), .pix_mode(pix_mode), .fifo_rclk(fifo_rclk_a), .fifo_wen(fifo_wen_a),
    .fifo_wrst(fifo_wrst_a), .fifo_rrst(fifo_rrst_a), .fifo_oe(fifo_oe_a), .rd_addr(rd_addr),
    .rd_q(rd_q_a), .busy(busy_a), .frame_done(frame_done_a), .frame_cnt(frame_cnt_a), .err(err_a)
  );

  cam_fifo_capture #(.CAM_W(8), .CAM_H(4), .DS_SHIFT(1), .STORE_W(16), .RRST_CYC(4), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .cam_data(cam_data), .ov_vsync(ov_vsync), .start(start),
    .continuous(continuous), .pix_mode(pix_mode), .fifo_rclk(fifo_rclk_b), .fifo_wen(fifo_wen_b),
    .fifo_wrst(fifo_wrst_b), .fifo_rrst(fifo_rrst_b), .fifo_oe(fifo_oe_b), .rd_addr(rd_addr),
    .rd_q(rd_q_b), .busy(busy_b), .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .err(err_b)
  );

  // AL422B read side: pointer cleared while RRST is low, one byte per read clock otherwise.
  always @(posedge clk) begin
    if (!fifo_rrst_a)         rptr <= '0;
    else if (rptr != 7'd64)   rptr <= rptr + 7'd1;
  end
  assign cam_data = rptr[6] ? 8'h00 : fifo_mem[rptr[5:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    ov_vsync = 1'b1;
    tick(3);
    ov_vsync = 1'b0;
  endtask

  function automatic logic [15:0] fmt_ref(input int mode, input logic [15:0] p, input int sw);
    int r, g, b, v;
    r = int'(p >> 11);
    g = int'((p >> 5) & 16'h003F);
    b = int'(p & 16'h001F);
    case (mode)
      0:       v = (r / 4) * 64 + (g / 8) * 8 + (b / 4);
      1:       v = ((r * 8 + r / 4) + 2 * (g * 4 + g / 16) + (b * 8 + b / 4)) / 4;
      2:       v = int'(p) >> (16 - sw);
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  task automatic set_frame(input int kind, input logic [15:0] c);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0:       src[i] = c;
        1:       src[i] = 16'(i);
        default: src[i] = 16'($urandom);
      endcase
      fifo_mem[6'(2 * i)]     = src[i][15:8];
      fifo_mem[6'(2 * i + 1)] = src[i][7:0];
    end
  endtask

  // Buffer address k = y*4+x holds sensor pixel (2y)*8 + 2x.
  task automatic push_exp(input int mode);
    exp_t e;
    int   idx;
    for (int k = 0; k < 8; k++) begin
      idx = (2 * (k / 4)) * 8 + 2 * (k % 4);
      e.a = fmt_ref(mode, src[5'(idx)], 9);
      e.b = fmt_ref(mode, src[5'(idx)], 16);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_buf();
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      tick(1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (k == 0) last0 = e;
        chk("rd_q9", 32'(rd_q_a), 32'(e.a));
        chk("rd_q16", 32'(rd_q_b), 32'(e.b));
      end
    end
    have_prev = 1'b1;
  endtask

  task automatic grab(input int mode, input int kind, input logic [15:0] c, input bit do_start,
                      input bit cont_after);
    pix_mode = 2'(mode);
    if (do_start) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    tick(4);
    chk("arm_wen", 32'(fifo_wen_a), 32'd0);
    chk("arm_busy", 32'(busy_a), 32'd1);
    vs_pulse();
    chk("vs_wrst", 32'(fifo_wrst_a), 32'd0);
    tick(6);
    chk("wr_wen", 32'(fifo_wen_a), 32'd1);
    chk("wr_wrst", 32'(fifo_wrst_a), 32'd1);
    set_frame(kind, c);
    push_exp(mode);
    vs_pulse();
    chk("rrst_wen", 32'(fifo_wen_a), 32'd0);
    chk("rrst_low", 32'(fifo_rrst_a), 32'd0);
    pix_mode = 2'd3;
`ifdef CAM_DOUBLE_BUF_EN
    if (have_prev) begin
      rd_addr = '0;
      tick(30);
      chk("dbuf_hold", 32'(rd_q_a), 32'(last0.a));
    end
`endif
    n = 0;
    while (frame_done_a !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("done_seen", 32'(frame_done_a), 32'd1);
    tick(1);
    chk("done_pulse", 32'(frame_done_a), 32'd0);
    fcnt++;
    chk("frame_cnt", 32'(frame_cnt_a), 32'(fcnt));
    chk("post_busy", 32'(busy_a), 32'(cont_after));
    check_buf();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    ov_vsync   = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    pix_mode   = 2'd0;
    rd_addr    = '0;
    have_prev  = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_wen", 32'(fifo_wen_a), 32'd0);
    chk("rst_rrst", 32'(fifo_rrst_a), 32'd1);
    chk("rst_wrst", 32'(fifo_wrst_a), 32'd1);
    chk("rst_done", 32'(frame_done_a), 32'd0);
    chk("rst_cnt", 32'(frame_cnt_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_q", 32'(rd_q_a), 32'd0);
    chk("oe", 32'(fifo_oe_a), 32'd0);
    rst = 1'b1;
    tick(2);

    grab(0, 0, 16'hF800, 1'b1, 1'b0);
    grab(2, 1, 16'h0000, 1'b1, 1'b0);
    grab(1, 0, 16'hFFFF, 1'b1, 1'b0);
    grab(1, 0, 16'h0000, 1'b1, 1'b0);
    grab(0, 2, 16'h0000, 1'b1, 1'b0);

    // Vsync never arrives: sticky error after the timeout.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 1;
    while (busy_a && n < 200) begin
      tick(1);
      n++;
    end
    chk("to_err", 32'(err_a), 32'd1);
    chk("to_busy", 32'(busy_a), 32'd0);
    chk("to_cycles", 32'(n >= 62 && n <= 70), 32'd1);

    continuous = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("err_clr", 32'(err_a), 32'd0);
    grab(0, 1, 16'h0000, 1'b0, 1'b1);
    grab(1, 2, 16'h0000, 1'b0, 1'b1);
    continuous = 1'b0;
    grab(2, 2, 16'h0000, 1'b0, 1'b0);

    // Reset in the middle of readout.
    pix_mode = 2'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    vs_pulse();
    tick(6);
    set_frame(2, 16'h0000);
    vs_pulse();
    n = 0;
    while (!fifo_rrst_a && n < 20) begin
      tick(1);
      n++;
    end
    chk("rrst_rel", 32'(fifo_rrst_a), 32'd1);
    tick(1);
    chk("rd_busy", 32'(busy_a), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mr_busy", 32'(busy_a), 32'd0);
    chk("mr_wen", 32'(fifo_wen_a), 32'd0);
    chk("mr_rrst", 32'(fifo_rrst_a), 32'd1);
    chk("mr_cnt", 32'(frame_cnt_a), 32'd0);
    chk("mr_q", 32'(rd_q_a), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    fcnt      = 0;
    have_prev = 1'b0;
    grab(1, 2, 16'h0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
